// File: rtl/led_matrix_pkg.sv
// rtl/led_matrix_pkg.sv - glyph indices, 8x8 bitmaps and scan state type for the LED matrix driver
package led_matrix_pkg;

    localparam int GLYPH_0     = 0;
    localparam int GLYPH_1     = 1;
    localparam int GLYPH_2     = 2;
    localparam int GLYPH_3     = 3;
    localparam int GLYPH_4     = 4;
    localparam int GLYPH_5     = 5;
    localparam int GLYPH_6     = 6;
    localparam int GLYPH_7     = 7;
    localparam int GLYPH_8     = 8;
    localparam int GLYPH_9     = 9;
    localparam int GLYPH_HEART = 10;
    localparam int GLYPH_BLANK = 63;

    // Row 0 in the top byte, leftmost pixel in the MSB of each byte.
    localparam logic [63:0] BMP_0     = 64'h3C42464A5262423C;
    localparam logic [63:0] BMP_1     = 64'h081828080808083E;
    localparam logic [63:0] BMP_2     = 64'h3C42020C3040407E;
    localparam logic [63:0] BMP_3     = 64'h3C42021C0202423C;
    localparam logic [63:0] BMP_4     = 64'h040C1424447E0404;
    localparam logic [63:0] BMP_5     = 64'h7E40407C0202423C;
    localparam logic [63:0] BMP_6     = 64'h1C20407C4242423C;
    localparam logic [63:0] BMP_7     = 64'h7E02040810101010;
    localparam logic [63:0] BMP_8     = 64'h3C42423C4242423C;
    localparam logic [63:0] BMP_9     = 64'h3C4242423E020438;
    localparam logic [63:0] BMP_HEART = 64'h0000247E7E3C1800;

    typedef enum logic {
        SCAN_BLANK,
        SCAN_DRIVE
    } scan_state_t;

    // Any index without a glyph renders dark rather than holding old content.
    function automatic logic [63:0] glyph_bitmap8(input int idx);
        case (idx)
            GLYPH_0:     return BMP_0;
            GLYPH_1:     return BMP_1;
            GLYPH_2:     return BMP_2;
            GLYPH_3:     return BMP_3;
            GLYPH_4:     return BMP_4;
            GLYPH_5:     return BMP_5;
            GLYPH_6:     return BMP_6;
            GLYPH_7:     return BMP_7;
            GLYPH_8:     return BMP_8;
            GLYPH_9:     return BMP_9;
            GLYPH_HEART: return BMP_HEART;
            GLYPH_BLANK: return '0;
            default:     return '0;
        endcase
    endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// rtl/led_matrix_scan_if.sv - glyph index valid/ready handshake bundle
interface led_matrix_scan_if #(
    parameter int IDX_W = 6
) ();
    logic [IDX_W-1:0] glyph_idx;
    logic             glyph_valid;
    logic             glyph_ready;

    modport master (
        output glyph_idx,
        output glyph_valid,
        input  glyph_ready
    );

    modport slave (
        input  glyph_idx,
        input  glyph_valid,
        output glyph_ready
    );
endinterface

// File: rtl/led_glyph_rom.sv
// rtl/led_glyph_rom.sv - combinational glyph index to ROWS x COLS bitmap, cropped/zero-padded from 8x8
module led_glyph_rom
    import led_matrix_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int IDX_W = 6
) (
    input  logic [IDX_W-1:0]     idx,
    output logic [ROWS*COLS-1:0] bitmap
);

    logic [63:0] src;

    // Map the 8x8 source onto the target grid anchored at the top-left corner.
    always_comb begin
        src    = glyph_bitmap8(int'(idx));
        bitmap = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r < 8 && c < 8) begin
                    bitmap[ROWS*COLS-1-(r*COLS+c)] = src[63-(r*8+c)];
                end
            end
        end
    end

endmodule

// File: rtl/led_matrix_scan.sv
// rtl/led_matrix_scan.sv - double-buffered row-scanned LED matrix driver; LED_SCAN_PWM_EN enables brightness PWM
module led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int DWELL = 100,
    parameter int BLANK = 4,
    parameter int IDX_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    led_matrix_scan_if.slave     glyph,
    input  logic [3:0]           brightness,
    output logic [ROWS-1:0]      row,
    output logic [COLS-1:0]      col,
    output logic                 frame_start
);

    localparam int SLOT_W = $clog2(DWELL);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int NPIX   = ROWS * COLS;

    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(DWELL - 1);
    localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [ROWS-1:0]   ROW_TOP    = {1'b1, {(ROWS-1){1'b0}}};

    scan_state_t       state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
    logic              frame_last;

    logic              pend_full;
    logic [IDX_W-1:0]  pend_idx;
    logic [NPIX-1:0]   active;
    logic [NPIX-1:0]   rom_bitmap;
    logic [COLS-1:0]   row_bits;

    logic [ROWS-1:0]   row_nx;
    logic [COLS-1:0]   col_nx;
    logic              frame_start_nx;
    logic              pwm_off;

    led_glyph_rom #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .IDX_W (IDX_W)
    ) u_rom (
        .idx    (pend_idx),
        .bitmap (rom_bitmap)
    );

    assign glyph.glyph_ready = !pend_full;

    // The swap point: the final cycle of the last row's slot.
    assign frame_last = (state_q == SCAN_DRIVE) && (slot_q == SLOT_LAST) && (row_cnt_q == ROW_LAST);

    // Scan state, slot counter and row counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SCAN_BLANK;
            slot_q    <= '0;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    // Next-state logic: BLANK for BLANK cycles, DRIVE until the slot ends, then next row.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q + 1'b1;
        row_cnt_d = row_cnt_q;
        case (state_q)
            SCAN_BLANK: begin
                if (slot_q == BLANK_LAST) begin
                    state_d = SCAN_DRIVE;
                end
            end
            SCAN_DRIVE: begin
                if (slot_q == SLOT_LAST) begin
                    state_d   = SCAN_BLANK;
                    slot_d    = '0;
                    row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + 1'b1;
                end
            end
        endcase
    end

`ifdef LED_SCAN_PWM_EN
    logic [3:0] bright_q;
    logic [3:0] drive_phase;

    // Brightness is latched once per frame so duty never changes mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            bright_q <= '0;
        end else if (frame_start_nx) begin
            bright_q <= brightness;
        end
    end

    assign drive_phase = 4'(slot_q - SLOT_W'(BLANK));
    assign pwm_off     = drive_phase > bright_q;
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign pwm_off           = 1'b0;
`endif

    // Column data for the row being driven, taken from the active buffer.
    always_comb begin
        row_bits = active[NPIX-1 - int'(row_cnt_q)*COLS -: COLS];
    end

    // Output decode from the current scan position; registered below.
    always_comb begin
        row_nx         = '0;
        col_nx         = '0;
        frame_start_nx = (state_q == SCAN_BLANK) && (slot_q == '0) && (row_cnt_q == '0);
        if (state_q == SCAN_DRIVE) begin
            row_nx = ROW_TOP >> row_cnt_q;
            if (!pwm_off) begin
                col_nx = row_bits;
            end
        end
    end

    // Registered pin outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            row         <= '0;
            col         <= '0;
            frame_start <= 1'b0;
        end else begin
            row         <= row_nx;
            col         <= col_nx;
            frame_start <= frame_start_nx;
        end
    end

    // Pending slot and active buffer: new glyphs only land at the frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_full <= 1'b0;
            pend_idx  <= '0;
            active    <= '0;
        end else if (frame_last && pend_full) begin
            active    <= rom_bitmap;
            pend_full <= 1'b0;
        end else if (glyph.glyph_valid && !pend_full) begin
            pend_full <= 1'b1;
            pend_idx  <= glyph.glyph_idx;
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb/tb_led_matrix_scan.sv - randomized scoreboard bench for led_matrix_scan
module tb_led_matrix_scan;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int DWELL = 100;
    localparam int BLANK = 4;
    localparam int IDX_W = 6;
    localparam int FRAME = ROWS * DWELL;

    logic             clk;
    logic             rst;
    logic [3:0]       brightness;
    logic [ROWS-1:0]  row;
    logic [COLS-1:0]  col;
    logic             frame_start;

    led_matrix_scan_if #(.IDX_W(IDX_W)) gif ();

    led_matrix_scan #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .DWELL (DWELL),
        .BLANK (BLANK),
        .IDX_W (IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .glyph       (gif),
        .brightness  (brightness),
        .row         (row),
        .col         (col),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          frame;
        logic [63:0] bmp;
    } sched_t;

    sched_t      sched[$];
    int          total = 0;
    int          bad   = 0;
    int          pe    = -1;
    bit          m_pend = 0;
    bit          m_in_rst = 0;
    bit          acc_seen = 0;
    logic [63:0] cur = '0;
`ifdef LED_SCAN_PWM_EN
    logic [3:0]  m_bright = '0;
`endif

    function automatic logic [63:0] ref_glyph(input int idx);
        case (idx)
            0:       return 64'h3C42464A5262423C;
            1:       return 64'h081828080808083E;
            2:       return 64'h3C42020C3040407E;
            3:       return 64'h3C42021C0202423C;
            4:       return 64'h040C1424447E0404;
            5:       return 64'h7E40407C0202423C;
            6:       return 64'h1C20407C4242423C;
            7:       return 64'h7E02040810101010;
            8:       return 64'h3C42423C4242423C;
            9:       return 64'h3C4242423E020438;
            10:      return 64'h0000247E7E3C1800;
            default: return 64'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, pe, act, exp);
        end
    endtask

    // Reference model: cycle position, pending slot and per-frame display schedule.
    always @(posedge clk) begin
        if (rst) begin
            pe       = -1;
            m_pend   = 0;
            m_in_rst = 1;
            acc_seen = 0;
            sched.delete();
        end else begin
            int pos;
            int fr;
            pe       = pe + 1;
            m_in_rst = 0;
            acc_seen = 0;
            pos      = pe % FRAME;
            fr       = pe / FRAME;
`ifdef LED_SCAN_PWM_EN
            if (pos == 0) m_bright = brightness;
`endif
            if (m_pend && pos == FRAME - 1) begin
                m_pend = 0;
            end else if (gif.glyph_valid && !m_pend) begin
                m_pend   = 1;
                acc_seen = 1;
                sched.push_back('{frame: fr + ((pos == FRAME - 1) ? 2 : 1),
                                  bmp: ref_glyph(int'(gif.glyph_idx))});
            end
        end
    end

    // Monitor: compare every output cycle against the model's expectation.
    always @(negedge clk) begin
        if (m_in_rst) begin
            cur = '0;
            check("reset_outputs", {14'd0, frame_start, gif.glyph_ready, row, col},
                  {14'd0, 1'b0, 1'b1, 8'h00, 8'h00});
        end else if (pe >= 0) begin
            int pos;
            int fr;
            int r;
            int s;
            logic [7:0] e_row;
            logic [7:0] e_col;
            pos = pe % FRAME;
            fr  = pe / FRAME;
            if (pos == 0) begin
                while (sched.size() > 0 && sched[0].frame <= fr) begin
                    cur = sched[0].bmp;
                    void'(sched.pop_front());
                end
            end
            r = pos / DWELL;
            s = pos % DWELL;
            e_row = 8'h00;
            e_col = 8'h00;
            if (s >= BLANK) begin
                e_row = 8'h80 >> r;
                e_col = cur[63 - 8*r -: 8];
`ifdef LED_SCAN_PWM_EN
                if (((s - BLANK) % 16) > int'(m_bright)) e_col = 8'h00;
`endif
            end
            check("scan", {14'd0, frame_start, gif.glyph_ready, row, col},
                  {14'd0, (pos == 0), !m_pend, e_row, e_col});
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [IDX_W-1:0] idx);
        bit done;
        done = 0;
        gif.glyph_idx   = idx;
        gif.glyph_valid = 1'b1;
        for (int i = 0; i < 3 * FRAME && !done; i++) begin
            @(posedge clk);
            #1;
            if (acc_seen) done = 1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout idx=%0d got=no_accept want=accept", idx);
        end
    endtask

    task automatic idle();
        gif.glyph_valid = 1'b0;
    endtask

    task automatic wait_pos(input int target);
        bit hit;
        hit = 0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            @(posedge clk);
            #1;
            if (pe >= 0 && (pe % FRAME) == target) hit = 1;
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL wait_pos got=timeout want=pos%0d", target);
        end
    endtask

    initial begin
        rst             = 1'b1;
        gif.glyph_valid = 1'b0;
        gif.glyph_idx   = '0;
        brightness      = 4'd3;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        wait_cycles(20);
        send(6'd1);
        idle();

        wait_cycles(1000);
        send(6'd1);
        send(6'd2);
        idle();

        wait_cycles(900);
        send(6'd63);
        idle();

        wait_cycles(900);
        for (int i = 0; i < 6; i++) begin
            wait_cycles($urandom_range(0, 1200));
            brightness = 4'($urandom_range(0, 15));
            send(6'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) send(6'($urandom_range(0, 15)));
            idle();
        end

        wait_cycles(FRAME + 10);
        wait_pos(5 * DWELL + 50);
        send(6'd8);
        idle();
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;

        wait_cycles(2 * FRAME + 10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
